oab_credit_ctrl: RTL and testbench

Player-facing credit and game-sequencing controller that sits directly upstream of the one-armed-bandit top.
- Accepts coin pulses and holds a saturating credit balance.
- Validates and debits the bet, then issues the one-cycle `roll` strobe and the registered `bet` value that drive the bandit.
- Samples the bandit's `payout`/`jackpot` result after a fixed latency and credits the winnings.
- Handles cash-out by emitting paced hopper pulses, one per credit.

---
 rtl/oab_pkg.sv | 33 +++
 rtl/oab_hopper_pacer.sv | 33 +++
 rtl/oab_credit_ctrl.sv | 166 ++++++++++++++++
 tb/tb_oab_credit_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oab_pkg.sv
// Shared types and helpers for the credit/game sequencing controller.
// Holds the FSM state encoding, default parameter values and the saturating credit adder.
package oab_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROLL,
        ST_WAIT,
        ST_CREDIT,
        ST_HOPPER_HI,
        ST_HOPPER_LO
    } credit_state_t;

    localparam int JACKPOT_BONUS_DEF = 100;
    localparam int BET_MAX_DEF       = 9;

    // The caller passes every operand already widened to int, so no
    // intermediate sum or difference can wrap. The result is then
    // clamped to the range 0..max_val.
    function automatic int sat_add(input int credits, input int add, input int sub,
                                   input int max_val);
        int sum;
        sum = credits + add - sub;
        if (sum < 0) begin
            return 0;
        end
        if (sum > max_val) begin
            return max_val;
        end
        return sum;
    endfunction

endpackage

// File: rtl/oab_hopper_pacer.sv
// Hopper pulse generation and inter-pulse gap timer for cash-out.
// start marks a pulse cycle; done flags the last low cycle of the gap that follows.
module oab_hopper_pacer #(
    parameter int GAP = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic dec,
    output logic hopper_pulse,
    output logic done
);

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (start) begin
            gap_cnt <= GW'(GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // The counter is reloaded on every pulse, so a value of 1 means this is the last low cycle of the gap.
    assign done         = (gap_cnt == GW'(1));
    assign dec          = start;
    assign hopper_pulse = start;

endmodule

// File: rtl/oab_credit_ctrl.sv
// Credit and game-sequencing controller in front of the one-armed bandit.
// Handles coins, bet validation and debit, result capture with winnings, and paced cash-out.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for cashout/play; coins accepted
// ST_ROLL      | bet debited and registered; roll strobe issued next cycle
// ST_WAIT      | counting bandit result latency
// ST_CREDIT    | payout/jackpot sampled and credited
// ST_HOPPER_HI | one coin dispensed this cycle
// ST_HOPPER_LO | gap between hopper pulses
module oab_credit_ctrl
    import oab_pkg::*;
#(
    parameter int CW            = 8,
    parameter int BET_MAX       = BET_MAX_DEF,
    parameter int RESULT_LAT    = 2,
    parameter int JACKPOT_BONUS = JACKPOT_BONUS_DEF,
    parameter int HOPPER_GAP    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_in,
    input  logic          play,
    input  logic [3:0]    bet_sel,
    input  logic          cashout,
    input  logic [3:0]    payout,
    input  logic          jackpot,
    output logic          roll,
    output logic [3:0]    bet,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          win,
    output logic          jackpot_lamp,
    output logic          hopper_pulse,
    output logic          err_nofunds
);

    localparam int MAX_CREDIT = (1 << CW) - 1;

    credit_state_t state, state_nxt;
    logic [7:0]    wait_cnt, wait_nxt;
    logic          roll_nxt, win_nxt, err_nxt;
    logic          bet_load, lamp_clr, lamp_set;
    logic          pace_start, pace_dec, pace_done;
    logic          play_ok, last_coin;
    int            credit_add, debit, credit_sum;
    logic [CW-1:0] credits_nxt;

    assign play_ok = (bet_sel != 4'd0) && (int'(bet_sel) <= BET_MAX)
                   && (int'(bet_sel) <= int'(credits));

    // Balance reaches zero after this pulse only if no coin arrives in the same cycle.
    assign last_coin = (credits == CW'(1)) && !coin_in;

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        roll_nxt   = 1'b0;
        win_nxt    = 1'b0;
        err_nxt    = 1'b0;
        bet_load   = 1'b0;
        lamp_clr   = 1'b0;
        lamp_set   = 1'b0;
        pace_start = 1'b0;
        credit_add = 0;
        debit      = 0;
        case (state)
            ST_IDLE: begin
                if (cashout) begin
                    if (credits != '0) begin
                        lamp_clr  = 1'b1;
                        state_nxt = ST_HOPPER_HI;
                    end
                end else if (play) begin
                    if (play_ok) begin
                        bet_load  = 1'b1;
                        lamp_clr  = 1'b1;
                        debit     = int'(bet_sel);
                        state_nxt = ST_ROLL;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_ROLL: begin
                roll_nxt = 1'b1;
                if (RESULT_LAT == 1) begin
                    state_nxt = ST_CREDIT;
                end else begin
                    wait_nxt  = 8'(RESULT_LAT - 1);
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_nxt = ST_CREDIT;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            ST_CREDIT: begin
                credit_add = int'(payout) + (jackpot ? JACKPOT_BONUS : 0);
                win_nxt    = (payout != 4'd0) || jackpot;
                lamp_set   = jackpot;
                state_nxt  = ST_IDLE;
            end
            ST_HOPPER_HI: begin
                pace_start = 1'b1;
                state_nxt  = last_coin ? ST_IDLE : ST_HOPPER_LO;
            end
            ST_HOPPER_LO: begin
                if (pace_done) begin
                    state_nxt = ST_HOPPER_HI;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign credit_sum  = sat_add(int'(credits), int'(coin_in) + credit_add,
                                 debit + int'(pace_dec), MAX_CREDIT);
    assign credits_nxt = credit_sum[CW-1:0];

    oab_hopper_pacer #(
        .GAP (HOPPER_GAP)
    ) u_pacer (
        .clk          (clk),
        .rst          (rst),
        .start        (pace_start),
        .dec          (pace_dec),
        .hopper_pulse (hopper_pulse),
        .done         (pace_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            credits      <= '0;
            bet          <= '0;
            wait_cnt     <= '0;
            roll         <= 1'b0;
            win          <= 1'b0;
            err_nofunds  <= 1'b0;
            jackpot_lamp <= 1'b0;
        end else begin
            state       <= state_nxt;
            credits     <= credits_nxt;
            wait_cnt    <= wait_nxt;
            roll        <= roll_nxt;
            win         <= win_nxt;
            err_nofunds <= err_nxt;
            if (bet_load) begin
                bet <= bet_sel;
            end
            if (lamp_clr) begin
                jackpot_lamp <= 1'b0;
            end else if (lamp_set) begin
                jackpot_lamp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oab_credit_ctrl.sv
// Directed self-checking bench for oab_credit_ctrl with default parameters.
// Expected values are hand-computed from the intended game and cash-out behaviour.
module tb_oab_credit_ctrl;

    localparam int RL  = 2;
    localparam int GAP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_in = 1'b0;
    logic       play = 1'b0;
    logic [3:0] bet_sel = 4'd0;
    logic       cashout = 1'b0;
    logic [3:0] payout = 4'd0;
    logic       jackpot = 1'b0;
    logic       roll;
    logic [3:0] bet;
    logic [7:0] credits;
    logic       busy;
    logic       win;
    logic       jackpot_lamp;
    logic       hopper_pulse;
    logic       err_nofunds;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oab_credit_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .play         (play),
        .bet_sel      (bet_sel),
        .cashout      (cashout),
        .payout       (payout),
        .jackpot      (jackpot),
        .roll         (roll),
        .bet          (bet),
        .credits      (credits),
        .busy         (busy),
        .win          (win),
        .jackpot_lamp (jackpot_lamp),
        .hopper_pulse (hopper_pulse),
        .err_nofunds  (err_nofunds)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_coins(input int n);
        for (int i = 0; i < n; i++) begin
            coin_in = 1'b1;
            step();
        end
        coin_in = 1'b0;
    endtask

    // Payout/jackpot are driven only during the single cycle they should be sampled.
    task automatic play_game(input int b, input int pay, input int jp, input int exp_debit,
                             input int exp_final, input int exp_win, input int exp_lamp);
        play    = 1'b1;
        bet_sel = 4'(b);
        step();
        play    = 1'b0;
        bet_sel = 4'd0;
        chk("game_busy_roll", busy, 1);
        chk("game_debit", credits, exp_debit);
        chk("game_bet", bet, b);
        chk("game_roll_early", roll, 0);
        step();
        chk("game_roll_hi", roll, 1);
        chk("game_busy_wait", busy, 1);
        for (int i = 0; i < RL; i++) begin
            step();
            chk("game_roll_once", roll, 0);
            chk("game_busy_lat", busy, 1);
        end
        payout  = 4'(pay);
        jackpot = (jp != 0);
        chk("game_bet_hold", bet, b);
        step();
        payout  = 4'd0;
        jackpot = 1'b0;
        chk("game_busy_end", busy, 0);
        chk("game_credits", credits, exp_final);
        chk("game_win", win, exp_win);
        chk("game_lamp", jackpot_lamp, exp_lamp);
        step();
        chk("game_win_pulse", win, 0);
        chk("game_bet_idle", bet, b);
    endtask

    // Entered on the first HOPPER_HI cycle; coin_pulse selects a pulse (1-based) to add a coin on.
    task automatic run_cashout(input int coin_pulse, input int exp_pulses);
        int pulses;
        int gap;
        int cyc;
        int rolls;
        pulses = 0;
        gap    = 0;
        cyc    = 0;
        rolls  = 0;
        while (busy && cyc < 2000) begin
            if (hopper_pulse) begin
                pulses++;
                if (pulses > 1) begin
                    chk("hop_gap", gap, GAP);
                end
                gap = 0;
                if (pulses == coin_pulse) begin
                    coin_in = 1'b1;
                end
            end else begin
                gap++;
            end
            rolls += int'(roll);
            step();
            coin_in = 1'b0;
            cyc++;
        end
        chk("hop_pulses", pulses, exp_pulses);
        chk("hop_busy_end", busy, 0);
        chk("hop_credits", credits, 0);
        chk("hop_no_roll", rolls, 0);
    endtask

    task automatic bad_play(input int b);
        play    = 1'b1;
        bet_sel = 4'(b);
        step();
        play    = 1'b0;
        bet_sel = 4'd0;
        chk("bad_err", err_nofunds, 1);
        chk("bad_busy", busy, 0);
        chk("bad_credits", credits, 3);
        step();
        chk("bad_err_pulse", err_nofunds, 0);
        chk("bad_no_roll", roll, 0);
        chk("bad_idle", busy, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_credits", credits, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bet", bet, 0);
        chk("rst_roll", roll, 0);
        chk("rst_hopper", hopper_pulse, 0);
        chk("rst_lamp", jackpot_lamp, 0);
        rst = 1'b1;
        step();

        add_coins(3);
        chk("coins_3", credits, 3);
        play_game(2, 0, 0, 1, 1, 0, 0);

        add_coins(4);
        chk("coins_5", credits, 5);
        play_game(3, 7, 0, 2, 9, 1, 0);

        add_coins(241);
        chk("coins_250", credits, 250);
        play_game(1, 4, 1, 249, 255, 1, 1);
        step();
        step();
        chk("lamp_hold", jackpot_lamp, 1);
        play_game(9, 0, 0, 246, 246, 0, 0);

        cashout = 1'b1;
        step();
        cashout = 1'b0;
        chk("big_cashout_start", hopper_pulse, 1);
        run_cashout(0, 246);

        add_coins(3);
        bad_play(0);
        bad_play(10);
        bad_play(4);
        chk("bet_keep", bet, 9);

        cashout = 1'b1;
        step();
        cashout = 1'b0;
        chk("cashout3_start", hopper_pulse, 1);
        run_cashout(0, 3);

        add_coins(3);
        cashout = 1'b1;
        step();
        cashout = 1'b0;
        run_cashout(1, 4);

        add_coins(4);
        play    = 1'b1;
        bet_sel = 4'd2;
        cashout = 1'b1;
        step();
        play    = 1'b0;
        bet_sel = 4'd0;
        cashout = 1'b0;
        chk("prio_hopper", hopper_pulse, 1);
        chk("prio_no_debit", credits, 4);
        run_cashout(0, 4);

        add_coins(2);
        play    = 1'b1;
        bet_sel = 4'd1;
        step();
        play    = 1'b0;
        bet_sel = 4'd0;
        step();
        chk("pre_rst_roll", roll, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_credits", credits, 0);
        chk("async_busy", busy, 0);
        chk("async_roll", roll, 0);
        chk("async_bet", bet, 0);
        payout  = 4'd5;
        jackpot = 1'b1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("post_rst_credits", credits, 0);
        chk("post_rst_win", win, 0);
        chk("post_rst_lamp", jackpot_lamp, 0);
        chk("post_rst_busy", busy, 0);
        payout  = 4'd0;
        jackpot = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
